adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Self-checking result monitor that sits directly downstream of the registered carry-select adder wrapper. It receives the same operand stream that drives the adder and the adder's registered `{cout, sum}` outputs. It delay-matches the operands to the adder latency, computes the golden result, and counts checked vectors and mismatches. It also captures the first failing vector for post-run readout, which gives STA builds a closed-loop functional check on hardware.

## Interface
Parameters:
- WIDTH, 8, operand/sum width; matches the adder.
- LATENCY, 2, cycles from operands presented at adder inputs to `{cout,sum}` valid at adder outputs; legal range 1..8.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  pulse; clears counters/capture and enters RUN.
- stop  in  1  pulse; ends acceptance and drains the pipeline.
- in_valid  in  1  operand vector present this cycle (same cycle it is driven into the adder).
- in_a, in_b  in  WIDTH  operands.
- in_cin  in  1  carry in.
- dut_sum  in  WIDTH  adder registered sum.
- dut_cout  in  1  adder registered carry out.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  level, high in DONE.
- pass  out  1  done && err_count==0.
- check_count  out  CNT_W  vectors compared.
- err_count  out  CNT_W  mismatches.
- first_err_valid  out  1  a mismatch has been captured.
- first_err_a, first_err_b  out  WIDTH  operands of the first mismatch.
- first_err_cin  out  1  carry in of the first mismatch.
- first_err_got  out  WIDTH+1  observed `{dut_cout,dut_sum}` at the first mismatch.
- first_err_exp  out  WIDTH+1  expected value at the first mismatch.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN.
  - Counters, first_err_*, and the pipeline are cleared on that edge.
  - start wins over a simultaneous stop.
- RUN:
  - in_valid pushes `{a,b,cin}` with a valid bit into a LATENCY-deep shift pipeline.
  - in_valid is ignored in every other state.
- RUN + stop → DRAIN. A vector with in_valid in the same cycle as stop is accepted.
- DRAIN: no pushes. Go to DONE when no valid entry remains in the pipeline or in the final compare stage.
- start while in RUN/DRAIN is ignored. stop outside RUN is ignored.
- Compare happens when the pipeline tail entry is valid:
  - exp = a + b + cin computed at WIDTH+1 bits (zero-extended, carry is the MSB).
  - got = {dut_cout, dut_sum}.
  - check_count increments. err_count increments if got≠exp.
- Both counters saturate at 2^CNT_W−1 and do not wrap.
- First mismatch only: load first_err_* and set first_err_valid. Later mismatches never overwrite the capture.
- Reset mid-run: immediate return to IDLE with every output 0. The in-flight pipeline is discarded.

## Timing
- Reset value of every output: 0, including pass and done.
- Vector accepted in cycle n is compared against dut_sum/dut_cout sampled in cycle n+LATENCY.
- Counters and capture update on the edge ending cycle n+LATENCY and are visible from cycle n+LATENCY+1.
- stop in cycle m, with the last vector at or before m:
  - done/pass are high from cycle m+LATENCY+1.
  - Counters are final in that same cycle.
  - busy drops in the same cycle done rises.
- Back-to-back in_valid every cycle is supported at full throughput with no bubbles.

## Structure
- Shared package `adder_chk_pkg`:
  - FSM state enum.
  - LATENCY max constant (8).
  - A packed vector-record typedef `{a, b, cin}` parameterised by WIDTH via localparam.
- Sub-module `latency_pipe`: parameterised LATENCY-deep shift of valid + payload, with a synchronous clear (driven by start) and an any-valid flag output for the drain exit.
- Top-level holds the FSM, golden adder, comparator, counters, and capture registers.

## Test plan
- Reset check: assert reset mid-RUN with 3 vectors in flight → all outputs 0 next cycle; state IDLE; no counter change after release.
- Clean run: start, then 4 consecutive vectors, stop with the 4th. Vectors:
  - (0x00,0x00,0)
  - (0xFF,0x01,1)
  - (0x7F,0x80,0)
  - (0xFF,0xFF,1)
  - Model the DUT as correct: exp 0x000, 0x101, 0x0FF, 0x1FF.
  - Required: check_count=4, err_count=0, pass=1, done at stop+LATENCY+1.
- Error injection: force dut_sum bit0 inverted on the 2nd and 3rd compares of the clean-run stream → err_count=2; first_err_a=0xFF, b=0x01, cin=1, exp=0x101, got=0x100; pass=0.
- Gaps and ignored input:
  - in_valid pulses with idle cycles between, plus in_valid asserted in IDLE and DRAIN → only RUN vectors are counted.
  - The check_count value matches the RUN-cycle valid count exactly.
- Simultaneous events:
  - start+stop together in IDLE → RUN entered.
  - in_valid with stop → that vector is counted.
  - start in DONE → counters read 0 the next cycle.
- Saturation: with CNT_W=4, push 20 mismatching vectors → err_count and check_count hold at 15.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder result checker.
package adder_chk_pkg;

  // Deepest operand delay the checker pipeline supports.
  localparam int LATENCY_MAX = 8;

  // Operand width of the reference adder configuration.
  localparam int VEC_WIDTH = 8;

  // Checker control states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

  // One operand vector as it travels down the delay pipeline.
  // The top level declares the same record at its own WIDTH.
  typedef struct packed {
    logic [VEC_WIDTH-1:0] a;
    logic [VEC_WIDTH-1:0] b;
    logic                 cin;
  } vec_rec_t;

endpackage

// File: rtl/latency_pipe.sv
// Fixed-depth shift pipeline of valid + payload that delays accepted
// operand vectors so they line up with the adder's registered outputs.
module latency_pipe #(
  parameter int DEPTH = 2,
  parameter int PW    = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push_valid,
  input  logic [PW-1:0] push_data,
  output logic          tail_valid,
  output logic [PW-1:0] tail_data,
  output logic          any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    data_q [DEPTH];

  // Shift every stage by one each cycle; clear empties the whole pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (clear) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid;
      data_q[0]  <= push_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_data  = data_q[DEPTH-1];

  // any_valid looks only at stages ahead of the tail: the tail entry is
  // compared this cycle, so once nothing is behind it the pipe is drained.
  generate
    if (DEPTH == 1) begin : g_single
      assign any_valid = 1'b0;
    end else begin : g_multi
      assign any_valid = |valid_q[DEPTH-2:0];
    end
  endgenerate

endmodule

// File: rtl/adder_result_checker.sv
// Closed-loop monitor for the registered carry-select adder: delays the
// operand stream to the adder latency, recomputes the golden sum, and keeps
// saturating check/error counters plus a capture of the first mismatch.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin,
  output logic [WIDTH:0]   first_err_got,
  output logic [WIDTH:0]   first_err_exp
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } vec_t;

  localparam int VW    = $bits(vec_t);
  localparam int DEPTH = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                         ((LATENCY < 1) ? 1 : LATENCY);

  chk_state_t     state;
  chk_state_t     state_next;
  logic           accept_start;
  logic           push_valid;
  logic           tail_valid;
  logic           any_valid;
  vec_t           push_vec;
  vec_t           tail_vec;
  logic [WIDTH:0] exp_sum;
  logic [WIDTH:0] got_sum;
  logic           mismatch;

  assign push_vec = '{a: in_a, b: in_b, cin: in_cin};

  latency_pipe #(
    .DEPTH (DEPTH),
    .PW    (VW)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept_start),
    .push_valid (push_valid),
    .push_data  (push_vec),
    .tail_valid (tail_valid),
    .tail_data  (tail_vec),
    .any_valid  (any_valid)
  );

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, pipeline push enable and status flags; start beats stop.
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    push_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_RUN;
          accept_start = 1'b1;
        end
      end
      ST_RUN: begin
        busy       = 1'b1;
        push_valid = in_valid;
        if (stop) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!any_valid) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_next   = ST_RUN;
          accept_start = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pass = done && (err_count == '0);

  // Golden result is zero-extended so the carry lands in the MSB.
  assign exp_sum  = {1'b0, tail_vec.a} + {1'b0, tail_vec.b}
                  + {{WIDTH{1'b0}}, tail_vec.cin};
  assign got_sum  = {dut_cout, dut_sum};
  assign mismatch = tail_valid && (got_sum != exp_sum);

  // Saturating counters of compared vectors and mismatches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_count <= '0;
      err_count   <= '0;
    end else if (accept_start) begin
      check_count <= '0;
      err_count   <= '0;
    end else if (tail_valid) begin
      if (check_count != '1)           check_count <= check_count + 1'b1;
      if (mismatch && err_count != '1) err_count   <= err_count + 1'b1;
    end
  end

  // Hold the very first mismatching vector until the next start or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
    end else if (accept_start) begin
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_a     <= tail_vec.a;
      first_err_b     <= tail_vec.b;
      first_err_cin   <= tail_vec.cin;
      first_err_got   <= got_sum;
      first_err_exp   <= exp_sum;
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: an ideal registered adder with optional
// sum-bit0 corruption feeds two checkers (16-bit and 4-bit counters); a
// scoreboard of accepted vectors supplies every expected value.
module tb_adder_result_checker;

  localparam int W   = 8;
  localparam int LAT = 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         inj;
  } sb_vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, in_valid, in_cin, dut_cout;
  logic [W-1:0] in_a, in_b, dut_sum;

  logic         busy, done, pass, fev, fe_cin;
  logic [15:0]  check_count, err_count;
  logic [W-1:0] fe_a, fe_b;
  logic [W:0]   fe_got, fe_exp;

  logic         s_busy, s_done, s_pass, s_fev, s_fe_cin;
  logic [3:0]   s_check_count, s_err_count;
  logic [W-1:0] s_fe_a, s_fe_b;
  logic [W:0]   s_fe_got, s_fe_exp;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic         running = 1'b0;
  logic [W:0]   hist [16];
  sb_vec_t      acc [$];

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(W), .LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .check_count(check_count), .err_count(err_count),
    .first_err_valid(fev), .first_err_a(fe_a), .first_err_b(fe_b),
    .first_err_cin(fe_cin), .first_err_got(fe_got), .first_err_exp(fe_exp)
  );

  adder_result_checker #(.WIDTH(W), .LATENCY(LAT), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .check_count(s_check_count), .err_count(s_err_count),
    .first_err_valid(s_fev), .first_err_a(s_fe_a), .first_err_b(s_fe_b),
    .first_err_cin(s_fe_cin), .first_err_got(s_fe_got), .first_err_exp(s_fe_exp)
  );

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, present the ideal adder output for the
  // vector driven LAT cycles ago, log accepted vectors, advance to negedge.
  task automatic apply_stimulus(input logic v, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic c,
                                input logic st, input logic sp,
                                input logic inj);
    logic [W:0] r;
    sb_vec_t    e;
    in_valid = v; in_a = a; in_b = b; in_cin = c; start = st; stop = sp;
    r = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    if (inj) r[0] = ~r[0];
    hist[cyc % 16] = r;
    if (cyc >= LAT) {dut_cout, dut_sum} = hist[(cyc - LAT) % 16];
    else            {dut_cout, dut_sum} = '0;
    if (running && v) begin
      e.a = a; e.b = b; e.cin = c; e.inj = inj;
      acc.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Final results expected from everything accepted since the last start.
  task automatic check_scoreboard(input string tag);
    int         n;
    int         e;
    int         first;
    logic [W:0] ex;
    n = acc.size();
    e = 0;
    first = -1;
    foreach (acc[i]) begin
      if (acc[i].inj) begin
        e++;
        if (first < 0) first = i;
      end
    end
    check_output({tag, "_check_count"}, 32'(check_count), 32'(n));
    check_output({tag, "_err_count"}, 32'(err_count), 32'(e));
    check_output({tag, "_pass"}, 32'(pass), 32'(e == 0));
    check_output({tag, "_first_err_valid"}, 32'(fev), 32'(e > 0));
    check_output({tag, "_sat_check_count"}, 32'(s_check_count), 32'((n > 15) ? 15 : n));
    check_output({tag, "_sat_err_count"}, 32'(s_err_count), 32'((e > 15) ? 15 : e));
    if (first >= 0) begin
      ex = (W+1)'(acc[first].a) + (W+1)'(acc[first].b) + (W+1)'(acc[first].cin);
      check_output({tag, "_first_a"}, 32'(fe_a), 32'(acc[first].a));
      check_output({tag, "_first_b"}, 32'(fe_b), 32'(acc[first].b));
      check_output({tag, "_first_cin"}, 32'(fe_cin), 32'(acc[first].cin));
      check_output({tag, "_first_exp"}, 32'(fe_exp), 32'(ex));
      check_output({tag, "_first_got"}, 32'(fe_got), 32'(ex ^ 9'h001));
    end
  endtask

  // Called in cycle m+1 after stop in cycle m: done must rise exactly at m+LAT+1.
  task automatic drain_check(input string tag, input logic drain_valid);
    for (int k = 1; k <= LAT; k++) begin
      check_output({tag, "_busy_draining"}, 32'(busy), 32'd1);
      check_output({tag, "_done_early"}, 32'(done), 32'd0);
      apply_stimulus(drain_valid, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_busy_off"}, 32'(busy), 32'd0);
    check_scoreboard(tag);
  endtask

  task automatic start_run();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    acc.delete();
    running = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_pass"}, 32'(pass), 32'd0);
    check_output({tag, "_counts"}, {check_count, err_count}, 32'd0);
    check_output({tag, "_capture"}, {14'd0, fev, fe_cin, fe_a, fe_b}, 32'd0);
    check_output({tag, "_capture_sums"}, 32'({fe_got, fe_exp}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; dut_sum = '0; dut_cout = 1'b0;
    @(negedge clk);
    idle_cycle();
    idle_cycle();
    check_all_zero("reset_state");
    reset = 1'b0;
    idle_cycle();

    // Reset in the middle of a run with three vectors in flight.
    $display("[TB] reset mid-run");
    start_run();
    apply_stimulus(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    idle_cycle();
    reset = 1'b0;
    running = 1'b0;
    acc.delete();
    for (int i = 0; i < 4; i++) idle_cycle();
    check_all_zero("after_reset_release");

    // Clean run: four back-to-back vectors, stop with the fourth.
    $display("[TB] clean run");
    start_run();
    apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    running = 1'b0;
    drain_check("clean", 1'b0);
    check_output("clean_count_const", 32'(check_count), 32'd4);
    check_output("clean_pass_const", 32'(pass), 32'd1);

    // Start from DONE clears everything; then inject errors on compares 2 and 3.
    $display("[TB] error injection");
    start_run();
    check_output("restart_counts_cleared", {check_count, err_count}, 32'd0);
    check_output("restart_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    running = 1'b0;
    drain_check("inject", 1'b0);
    check_output("inject_err_const", 32'(err_count), 32'd2);
    check_output("inject_got_const", 32'(fe_got), 32'h100);
    check_output("inject_exp_const", 32'(fe_exp), 32'h101);

    // Gaps, ignored in_valid in IDLE and DRAIN, start+stop together in IDLE.
    $display("[TB] gaps and ignored input");
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    apply_stimulus(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h56, 8'h78, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h9A, 8'hBC, 1'b0, 1'b1, 1'b1, 1'b0);
    acc.delete();
    running = 1'b1;
    check_output("start_stop_enters_run", 32'(busy), 32'd1);
    check_output("idle_valid_ignored", 32'(check_count), 32'd0);
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'(i % 3 == 0), 8'($urandom), 8'($urandom), 1'($urandom),
                     1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    running = 1'b0;
    drain_check("gaps", 1'b1);
    check_output("gaps_count_const", 32'(check_count), 32'd5);

    // Randomized stream with random gaps and random corrupted results.
    $display("[TB] random stream");
    start_run();
    for (int i = 0; i < 40; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                     1'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0));
    apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1,
                   1'($urandom_range(0, 1)));
    running = 1'b0;
    drain_check("random", 1'b0);

    // Saturation of the narrow counters with 20 mismatching vectors.
    $display("[TB] saturation");
    start_run();
    for (int i = 0; i < 19; i++)
      apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1);
    running = 1'b0;
    drain_check("saturate", 1'b0);
    check_output("sat_check_hold", 32'(s_check_count), 32'd15);
    check_output("sat_err_hold", 32'(s_err_count), 32'd15);
    check_output("wide_err_20", 32'(err_count), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
